// File: rtl/npu_os_sequencer_pkg.sv
// ============================================================================
// pkg_npu_seq: shared states, register offsets and opcodes for the OS sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

package pkg_npu_seq;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      FLOW     = 3'd1,
      SKEW     = 3'd2,
      DRAIN    = 3'd3,
      STORE    = 3'd4,
      TILE_END = 3'd5,
      INTRA    = 3'd6,
      FINISH   = 3'd7
   } state_t;

   localparam logic [7:0] OFF_CTRL     = 8'h00;
   localparam logic [7:0] OFF_STATUS   = 8'h04;
   localparam logic [7:0] OFF_A_BASE   = 8'h08;
   localparam logic [7:0] OFF_ROWS     = 8'h0C;
   localparam logic [7:0] OFF_W_BASE   = 8'h10;
   localparam logic [7:0] OFF_COLS     = 8'h14;
   localparam logic [7:0] OFF_O_BASE   = 8'h18;
   localparam logic [7:0] OFF_INTRA_O  = 8'h1C;
   localparam logic [7:0] OFF_INTRA_A  = 8'h20;
   localparam logic [7:0] OFF_K        = 8'h24;
   localparam logic [7:0] OFF_TILES    = 8'h28;
   localparam logic [7:0] OFF_A_STRIDE = 8'h2C;
   localparam logic [7:0] OFF_O_STRIDE = 8'h30;

   localparam int CTRL_START_OS    = 0;
   localparam int CTRL_START_INTRA = 1;
   localparam int CTRL_ABORT       = 2;

   localparam logic [2:0] OP_IDLE  = 3'b000;
   localparam logic [2:0] OP_FLOW  = 3'b100;
   localparam logic [2:0] OP_DRAIN = 3'b110;

   // A tile count of zero still runs one tile.
   function automatic logic [31:0] tiles_eff(input logic [31:0] t);
      return (t == 32'd0) ? 32'd1 : t;
   endfunction

endpackage

`default_nettype wire

// File: rtl/npu_os_sequencer_regfile.sv
// ============================================================================
// npu_seq_regfile: bus-mapped configuration, control strobes and sticky status
// Revision: 1.0
// ============================================================================
`default_nettype none

module npu_seq_regfile
   import pkg_npu_seq::*;
#(
   parameter int                    DWidth     = 32,
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] PARA_BASE  = '0
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  cen_i,
   input  logic                  wen_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DWidth-1:0]     wdata_i,
   output logic [DWidth-1:0]     rdata_o,
   input  logic                  busy_i,
   input  logic                  set_done_i,
   input  logic                  set_err_i,
   output logic                  start_os_o,
   output logic                  start_intra_o,
   output logic                  abort_o,
   output logic [ADDR_WIDTH-1:0] a_base_o,
   output logic [ADDR_WIDTH-1:0] w_base_o,
   output logic [ADDR_WIDTH-1:0] o_base_o,
   output logic [ADDR_WIDTH-1:0] intra_o_base_o,
   output logic [ADDR_WIDTH-1:0] intra_a_base_o,
   output logic [ADDR_WIDTH-1:0] a_stride_o,
   output logic [ADDR_WIDTH-1:0] o_stride_o,
   output logic [DWidth-1:0]     rows_o,
   output logic [DWidth-1:0]     cols_o,
   output logic [DWidth-1:0]     k_o,
   output logic [DWidth-1:0]     tiles_o
);

   logic [ADDR_WIDTH-1:0] w_off;
   logic [7:0]            w_idx;
   logic                  w_hit;
   logic                  w_wr;
   logic                  w_rd;
   logic                  w_ctrl_wr;
   logic                  w_status_rd;
   logic [DWidth-1:0]     w_rd_val;

   logic [ADDR_WIDTH-1:0] a_base_q, w_base_q, o_base_q, intra_o_q, intra_a_q;
   logic [ADDR_WIDTH-1:0] a_stride_q, o_stride_q;
   logic [DWidth-1:0]     rows_q, cols_q, k_q, tiles_q;
   logic                  done_q, err_q;
   logic [DWidth-1:0]     rdata_q;

   assign w_off       = addr_i - PARA_BASE;
   assign w_idx       = w_off[7:0];
   assign w_hit       = ((w_off >> 8) == '0);
   assign w_wr        = cen_i & wen_i & w_hit;
   assign w_rd        = cen_i & ~wen_i;
   assign w_ctrl_wr   = w_wr & (w_idx == OFF_CTRL);
   assign w_status_rd = w_rd & w_hit & (w_idx == OFF_STATUS);

   assign start_os_o    = w_ctrl_wr & wdata_i[CTRL_START_OS];
   assign start_intra_o = w_ctrl_wr & wdata_i[CTRL_START_INTRA];
   assign abort_o       = w_ctrl_wr & wdata_i[CTRL_ABORT];

   // Dimensions and bases are frozen for the whole run once the sequencer is busy.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         a_base_q   <= '0;
         w_base_q   <= '0;
         o_base_q   <= '0;
         intra_o_q  <= '0;
         intra_a_q  <= '0;
         a_stride_q <= '0;
         o_stride_q <= '0;
         rows_q     <= '0;
         cols_q     <= '0;
         k_q        <= '0;
         tiles_q    <= '0;
      end else if (w_wr && !busy_i) begin
         case (w_idx)
            OFF_A_BASE:   a_base_q   <= ADDR_WIDTH'(wdata_i);
            OFF_ROWS:     rows_q     <= wdata_i;
            OFF_W_BASE:   w_base_q   <= ADDR_WIDTH'(wdata_i);
            OFF_COLS:     cols_q     <= wdata_i;
            OFF_O_BASE:   o_base_q   <= ADDR_WIDTH'(wdata_i);
            OFF_INTRA_O:  intra_o_q  <= ADDR_WIDTH'(wdata_i);
            OFF_INTRA_A:  intra_a_q  <= ADDR_WIDTH'(wdata_i);
            OFF_K:        k_q        <= wdata_i;
            OFF_TILES:    tiles_q    <= wdata_i;
            OFF_A_STRIDE: a_stride_q <= ADDR_WIDTH'(wdata_i);
            OFF_O_STRIDE: o_stride_q <= ADDR_WIDTH'(wdata_i);
            default: ;
         endcase
      end
   end

   // A new event in the same cycle as a STATUS read survives the clear.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         if (set_done_i)       done_q <= 1'b1;
         else if (w_status_rd) done_q <= 1'b0;
         if (set_err_i)        err_q  <= 1'b1;
         else if (w_status_rd) err_q  <= 1'b0;
      end
   end

   always_comb begin
      w_rd_val = '0;
      if (w_hit) begin
         case (w_idx)
            OFF_STATUS:   w_rd_val = DWidth'({err_q, done_q, busy_i});
            OFF_A_BASE:   w_rd_val = DWidth'(a_base_q);
            OFF_ROWS:     w_rd_val = rows_q;
            OFF_W_BASE:   w_rd_val = DWidth'(w_base_q);
            OFF_COLS:     w_rd_val = cols_q;
            OFF_O_BASE:   w_rd_val = DWidth'(o_base_q);
            OFF_INTRA_O:  w_rd_val = DWidth'(intra_o_q);
            OFF_INTRA_A:  w_rd_val = DWidth'(intra_a_q);
            OFF_K:        w_rd_val = k_q;
            OFF_TILES:    w_rd_val = tiles_q;
            OFF_A_STRIDE: w_rd_val = DWidth'(a_stride_q);
            OFF_O_STRIDE: w_rd_val = DWidth'(o_stride_q);
            default:      w_rd_val = '0;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)   rdata_q <= '0;
      else if (w_rd) rdata_q <= w_rd_val;
   end

   assign rdata_o        = rdata_q;
   assign a_base_o       = a_base_q;
   assign w_base_o       = w_base_q;
   assign o_base_o       = o_base_q;
   assign intra_o_base_o = intra_o_q;
   assign intra_a_base_o = intra_a_q;
   assign a_stride_o     = a_stride_q;
   assign o_stride_o     = o_stride_q;
   assign rows_o         = rows_q;
   assign cols_o         = cols_q;
   assign k_o            = k_q;
   assign tiles_o        = tiles_q;

endmodule

`default_nettype wire

// File: rtl/npu_os_sequencer.sv
// ============================================================================
// npu_os_sequencer: output-stationary systolic tile sequencer with intranet mode
// Revision: 1.0
// ============================================================================
`default_nettype none

module npu_os_sequencer
   import pkg_npu_seq::*;
#(
   parameter int                    DWidth     = 32,
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    ARRAY_N    = 16,
   parameter int                    ARRAY_M    = 16,
   parameter logic [ADDR_WIDTH-1:0] PARA_BASE  = '0
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        cen_i,
   input  logic                        wen_i,
   input  logic [ADDR_WIDTH-1:0]       addr_i,
   input  logic [DWidth-1:0]           wdata_i,
   output logic [DWidth-1:0]           rdata_o,
   output logic                        a_buf_on,
   output logic                        w_buf_on,
   output logic                        o_ag_o_on,
   output logic                        sa_reset,
   output logic                        intranet_on,
   output logic                        intra_sig_start,
   output logic [2:0]                  operation_signal_in,
   output logic [ADDR_WIDTH-1:0]       a_base_addr,
   output logic [ADDR_WIDTH-1:0]       w_base_addr,
   output logic [ADDR_WIDTH-1:0]       o_base_addr,
   output logic [ADDR_WIDTH-1:0]       intra_o_base_addr,
   output logic [ADDR_WIDTH-1:0]       intra_a_base_addr,
   output logic [$clog2(ARRAY_N):0]    a_num_rows,
   output logic [$clog2(ARRAY_M):0]    w_num_cols,
   output logic                        busy_o,
   output logic                        done_irq_o
);

   localparam int ROWS_W = $clog2(ARRAY_N) + 1;
   localparam int COLS_W = $clog2(ARRAY_M) + 1;

   logic                  w_start_os, w_start_intra, w_abort;
   logic                  w_set_done, w_set_err;
   logic [ADDR_WIDTH-1:0] cfg_a_base, cfg_o_base, cfg_a_stride, cfg_o_stride;
   logic [DWidth-1:0]     cfg_rows, cfg_cols, cfg_k, cfg_tiles;

   state_t                state_q, state_d;
   logic [31:0]           cnt_q, cnt_d;
   logic [31:0]           tiles_q, tiles_d;
   logic [ADDR_WIDTH-1:0] a_cur_q, a_cur_d, o_cur_q, o_cur_d;

   logic [31:0]           w_rows, w_cols, w_k, w_len;
   logic                  w_last, w_cfg_bad;

   npu_seq_regfile #(
      .DWidth     (DWidth),
      .ADDR_WIDTH (ADDR_WIDTH),
      .PARA_BASE  (PARA_BASE)
   ) u_regfile (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .cen_i          (cen_i),
      .wen_i          (wen_i),
      .addr_i         (addr_i),
      .wdata_i        (wdata_i),
      .rdata_o        (rdata_o),
      .busy_i         (busy_o),
      .set_done_i     (w_set_done),
      .set_err_i      (w_set_err),
      .start_os_o     (w_start_os),
      .start_intra_o  (w_start_intra),
      .abort_o        (w_abort),
      .a_base_o       (cfg_a_base),
      .w_base_o       (w_base_addr),
      .o_base_o       (cfg_o_base),
      .intra_o_base_o (intra_o_base_addr),
      .intra_a_base_o (intra_a_base_addr),
      .a_stride_o     (cfg_a_stride),
      .o_stride_o     (cfg_o_stride),
      .rows_o         (cfg_rows),
      .cols_o         (cfg_cols),
      .k_o            (cfg_k),
      .tiles_o        (cfg_tiles)
   );

   assign w_rows = 32'(cfg_rows);
   assign w_cols = 32'(cfg_cols);
   assign w_k    = 32'(cfg_k);

   assign w_cfg_bad = (w_k == 32'd0) || (w_rows == 32'd0) || (w_cols == 32'd0) ||
                      (w_rows > 32'(ARRAY_N)) || (w_cols > 32'(ARRAY_M));

   // Every phase that uses the counter is at least one cycle long by construction.
   always_comb begin
      w_len = 32'd1;
      case (state_q)
         FLOW:    w_len = w_k;
         SKEW:    w_len = w_rows + w_cols - 32'd1;
         DRAIN:   w_len = 32'(ARRAY_N) - w_rows;
         STORE:   w_len = w_rows + 32'd1;
         INTRA:   w_len = w_rows + w_cols + 32'd1;
         default: w_len = 32'd1;
      endcase
   end

   assign w_last = (cnt_q == w_len - 32'd1);

   always_comb begin
      state_d             = state_q;
      a_buf_on            = 1'b0;
      w_buf_on            = 1'b0;
      o_ag_o_on           = 1'b0;
      sa_reset            = 1'b0;
      intranet_on         = 1'b0;
      intra_sig_start     = 1'b0;
      operation_signal_in = OP_IDLE;
      done_irq_o          = 1'b0;
      w_set_done          = 1'b0;
      w_set_err           = 1'b0;
      case (state_q)
         IDLE: begin
            sa_reset = 1'b1;
            if (!w_abort) begin
               if (w_start_os) begin
                  if (w_cfg_bad) w_set_err = 1'b1;
                  else           state_d   = FLOW;
               end else if (w_start_intra) begin
                  state_d = INTRA;
               end
            end
         end
         FLOW: begin
            a_buf_on            = 1'b1;
            w_buf_on            = 1'b1;
            operation_signal_in = OP_FLOW;
            if (w_last) state_d = SKEW;
         end
         SKEW: begin
            operation_signal_in = OP_FLOW;
            if (w_last) state_d = (w_rows == 32'(ARRAY_N)) ? STORE : DRAIN;
         end
         DRAIN: begin
            operation_signal_in = OP_DRAIN;
            if (w_last) state_d = STORE;
         end
         STORE: begin
            o_ag_o_on           = 1'b1;
            operation_signal_in = OP_DRAIN;
            if (w_last) state_d = TILE_END;
         end
         TILE_END: begin
            sa_reset = 1'b1;
            state_d  = (tiles_q > 32'd1) ? FLOW : FINISH;
         end
         INTRA: begin
            intranet_on     = 1'b1;
            intra_sig_start = 1'b1;
            if (w_last) state_d = FINISH;
         end
         FINISH: begin
            done_irq_o = 1'b1;
            w_set_done = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Abort silences the datapath in the same cycle it is written.
      if (w_abort && (state_q != IDLE)) begin
         state_d             = IDLE;
         a_buf_on            = 1'b0;
         w_buf_on            = 1'b0;
         o_ag_o_on           = 1'b0;
         intranet_on         = 1'b0;
         intra_sig_start     = 1'b0;
         operation_signal_in = OP_IDLE;
         done_irq_o          = 1'b0;
         w_set_done          = 1'b0;
         sa_reset            = 1'b1;
      end
   end

   always_comb begin
      cnt_d   = (state_d != state_q) ? 32'd0 : cnt_q + 32'd1;
      tiles_d = tiles_q;
      a_cur_d = a_cur_q;
      o_cur_d = o_cur_q;
      if (state_q == IDLE) begin
         tiles_d = tiles_eff(32'(cfg_tiles));
         a_cur_d = cfg_a_base;
         o_cur_d = cfg_o_base;
      end else if ((state_q == TILE_END) && (state_d == FLOW)) begin
         tiles_d = tiles_q - 32'd1;
         a_cur_d = a_cur_q + cfg_a_stride;
         o_cur_d = o_cur_q + cfg_o_stride;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         tiles_q <= '0;
         a_cur_q <= '0;
         o_cur_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tiles_q <= tiles_d;
         a_cur_q <= a_cur_d;
         o_cur_q <= o_cur_d;
      end
   end

   // In IDLE the programmed bases show through, so per-tile offsets vanish after a run.
   assign a_base_addr = (state_q == IDLE) ? cfg_a_base : a_cur_q;
   assign o_base_addr = (state_q == IDLE) ? cfg_o_base : o_cur_q;
   assign a_num_rows  = ROWS_W'(cfg_rows);
   assign w_num_cols  = COLS_W'(cfg_cols);
   assign busy_o      = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_npu_os_sequencer.sv
// ============================================================================
// tb_npu_os_sequencer: directed table-driven bench for the OS sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_npu_os_sequencer;

   localparam logic [31:0] A_CTRL = 32'h00, A_STATUS = 32'h04, A_ABASE = 32'h08;
   localparam logic [31:0] A_ROWS = 32'h0C, A_WBASE = 32'h10, A_COLS = 32'h14;
   localparam logic [31:0] A_OBASE = 32'h18, A_INTRAO = 32'h1C, A_INTRAA = 32'h20;
   localparam logic [31:0] A_K = 32'h24, A_TILES = 32'h28, A_ASTR = 32'h2C, A_OSTR = 32'h30;

   localparam int C_FLOW = 0, C_SKEW = 1, C_DRAIN = 2, C_STORE = 3;
   localparam int C_TE = 4, C_INTRA = 5, C_FIN = 6, C_OTHER = 7;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        cen, wen;
   logic [31:0] addr, wdata, rdata;
   logic        a_buf_on, w_buf_on, o_ag_o_on, sa_reset, intranet_on, intra_sig_start;
   logic [2:0]  op;
   logic [31:0] a_base_addr, w_base_addr, o_base_addr, intra_o_base_addr, intra_a_base_addr;
   logic [4:0]  a_num_rows, w_num_cols;
   logic        busy_o, done_irq_o;

   int n_tests = 0;
   int n_fail  = 0;

   int          cnt [8];
   int          done_at;
   int          n_ent;
   logic [31:0] a_ent [4];
   logic [31:0] o_ent [4];

   always #5 clk = ~clk;

   npu_os_sequencer dut (
      .clk_i               (clk),
      .rst_ni              (rst_ni),
      .cen_i               (cen),
      .wen_i               (wen),
      .addr_i              (addr),
      .wdata_i             (wdata),
      .rdata_o             (rdata),
      .a_buf_on            (a_buf_on),
      .w_buf_on            (w_buf_on),
      .o_ag_o_on           (o_ag_o_on),
      .sa_reset            (sa_reset),
      .intranet_on         (intranet_on),
      .intra_sig_start     (intra_sig_start),
      .operation_signal_in (op),
      .a_base_addr         (a_base_addr),
      .w_base_addr         (w_base_addr),
      .o_base_addr         (o_base_addr),
      .intra_o_base_addr   (intra_o_base_addr),
      .intra_a_base_addr   (intra_a_base_addr),
      .a_num_rows          (a_num_rows),
      .w_num_cols          (w_num_cols),
      .busy_o              (busy_o),
      .done_irq_o          (done_irq_o)
   );

   typedef struct {
      bit          wr;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] e;
   } reg_vec_t;

   typedef struct {
      int rows, cols, k, tiles;
      int e_flow, e_skew, e_drain, e_store, e_te, e_done;
   } run_vec_t;

   typedef struct {
      int k, rows, cols;
   } err_vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Bus tasks are entered on a falling edge and return on the next one.
   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      cen = 1'b1; wen = 1'b1; addr = a; wdata = d;
      @(negedge clk);
      cen = 1'b0; wen = 1'b0; wdata = '0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      cen = 1'b1; wen = 1'b0; addr = a;
      @(negedge clk);
      cen = 1'b0;
      d = rdata;
   endtask

   task automatic cfg(input int rows, input int cols, input int k, input int tiles);
      wr(A_ROWS, rows);
      wr(A_COLS, cols);
      wr(A_K, k);
      wr(A_TILES, tiles);
   endtask

   function automatic int classify();
      if (done_irq_o)                                   return C_FIN;
      if (a_buf_on && w_buf_on && op == 3'b100)         return C_FLOW;
      if (intranet_on && intra_sig_start && op == 3'b000) return C_INTRA;
      if (o_ag_o_on && op == 3'b110)                    return C_STORE;
      if (!o_ag_o_on && !a_buf_on && op == 3'b110)      return C_DRAIN;
      if (!a_buf_on && !w_buf_on && op == 3'b100)       return C_SKEW;
      if (sa_reset && op == 3'b000 && !intranet_on)     return C_TE;
      return C_OTHER;
   endfunction

   // Sample 0 is the first cycle after the start write; runs until busy drops.
   task automatic observe();
      int prev;
      int cls;
      bit ended;
      for (int i = 0; i < 8; i++) cnt[i] = 0;
      done_at = -1; n_ent = 0; prev = -1; ended = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (!busy_o) begin
            ended = 1'b1;
            break;
         end
         cls = classify();
         cnt[cls]++;
         if (cls == C_FIN) done_at = cyc;
         if (cls == C_FLOW && prev != C_FLOW && n_ent < 4) begin
            a_ent[n_ent] = a_base_addr;
            o_ent[n_ent] = o_base_addr;
            n_ent++;
         end
         prev = cls;
         @(negedge clk);
      end
      chk("run_terminates", 32'(ended), 32'd1);
   endtask

   initial begin
      reg_vec_t    rv [$];
      run_vec_t    runs [$];
      err_vec_t    errs [$];
      logic [31:0] d;
      int          seen;
      bit          got;

      rv.push_back('{1'b1, A_ABASE,  32'h1234_5678, 32'h0});
      rv.push_back('{1'b0, A_ABASE,  32'h0,         32'h1234_5678});
      rv.push_back('{1'b1, A_WBASE,  32'hA0,        32'h0});
      rv.push_back('{1'b0, A_WBASE,  32'h0,         32'hA0});
      rv.push_back('{1'b1, A_INTRAO, 32'h55,        32'h0});
      rv.push_back('{1'b0, A_INTRAO, 32'h0,         32'h55});
      rv.push_back('{1'b1, A_INTRAA, 32'h66,        32'h0});
      rv.push_back('{1'b0, A_INTRAA, 32'h0,         32'h66});
      rv.push_back('{1'b1, A_ROWS,   32'd5,         32'h0});
      rv.push_back('{1'b0, A_ROWS,   32'h0,         32'd5});
      rv.push_back('{1'b1, A_COLS,   32'd7,         32'h0});
      rv.push_back('{1'b0, A_COLS,   32'h0,         32'd7});
      rv.push_back('{1'b1, A_K,      32'd9,         32'h0});
      rv.push_back('{1'b0, A_K,      32'h0,         32'd9});
      rv.push_back('{1'b1, A_TILES,  32'd2,         32'h0});
      rv.push_back('{1'b0, A_TILES,  32'h0,         32'd2});
      rv.push_back('{1'b1, A_ASTR,   32'h40,        32'h0});
      rv.push_back('{1'b0, A_ASTR,   32'h0,         32'h40});
      rv.push_back('{1'b1, A_OSTR,   32'h10,        32'h0});
      rv.push_back('{1'b0, A_OSTR,   32'h0,         32'h10});
      rv.push_back('{1'b1, A_OBASE,  32'h800,       32'h0});
      rv.push_back('{1'b0, A_OBASE,  32'h0,         32'h800});
      rv.push_back('{1'b0, A_CTRL,   32'h0,         32'h0});
      rv.push_back('{1'b1, 32'h34,   32'hFFFF,      32'h0});
      rv.push_back('{1'b0, 32'h34,   32'h0,         32'h0});
      rv.push_back('{1'b0, 32'h0A,   32'h0,         32'h0});
      rv.push_back('{1'b1, A_STATUS, 32'h7,         32'h0});
      rv.push_back('{1'b0, A_STATUS, 32'h0,         32'h0});

      //                rows cols k tiles  flow skew drain store te done
      runs.push_back('{16, 16, 4, 1,   4,  31,   0,  17, 1, 53});
      runs.push_back('{ 4, 16, 8, 1,   8,  19,  12,   5, 1, 45});
      runs.push_back('{ 1,  1, 1, 1,   1,   1,  15,   2, 1, 20});
      runs.push_back('{ 3,  2, 2, 2,   4,   8,  26,   8, 2, 48});
      runs.push_back('{ 8,  8, 1, 0,   1,  15,   8,   9, 1, 34});

      errs.push_back('{0,  4,  4});
      errs.push_back('{1,  0,  4});
      errs.push_back('{1,  4,  0});
      errs.push_back('{1, 17,  4});
      errs.push_back('{1,  4, 17});

      rst_ni = 1'b0; cen = 1'b0; wen = 1'b0; addr = '0; wdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy",     32'(busy_o),   32'd0);
      chk("rst_sa_reset", 32'(sa_reset), 32'd1);
      chk("rst_strobes",  32'({a_buf_on, w_buf_on, o_ag_o_on, intranet_on, intra_sig_start, done_irq_o}), 32'd0);
      chk("rst_opcode",   32'(op),       32'd0);
      chk("rst_rdata",    rdata,         32'd0);
      chk("rst_a_base",   a_base_addr,   32'd0);
      rst_ni = 1'b1;
      @(negedge clk);

      foreach (rv[i]) begin
         if (rv[i].wr) begin
            wr(rv[i].a, rv[i].d);
         end else begin
            rd(rv[i].a, d);
            chk($sformatf("reg_vec[%0d]@%0h", i, rv[i].a), d, rv[i].e);
         end
      end
      chk("out_a_base",  a_base_addr,       32'h1234_5678);
      chk("out_w_base",  w_base_addr,       32'hA0);
      chk("out_o_base",  o_base_addr,       32'h800);
      chk("out_intra_o", intra_o_base_addr, 32'h55);
      chk("out_intra_a", intra_a_base_addr, 32'h66);
      chk("out_rows",    32'(a_num_rows),   32'd5);
      chk("out_cols",    32'(w_num_cols),   32'd7);

      foreach (runs[i]) begin
         cfg(runs[i].rows, runs[i].cols, runs[i].k, runs[i].tiles);
         wr(A_CTRL, 32'h1);
         observe();
         chk($sformatf("run%0d_flow", i),  cnt[C_FLOW],  runs[i].e_flow);
         chk($sformatf("run%0d_skew", i),  cnt[C_SKEW],  runs[i].e_skew);
         chk($sformatf("run%0d_drain", i), cnt[C_DRAIN], runs[i].e_drain);
         chk($sformatf("run%0d_store", i), cnt[C_STORE], runs[i].e_store);
         chk($sformatf("run%0d_tile_end", i), cnt[C_TE], runs[i].e_te);
         chk($sformatf("run%0d_done_at", i), done_at,    runs[i].e_done);
         chk($sformatf("run%0d_done_pulses", i), cnt[C_FIN], 32'd1);
         chk($sformatf("run%0d_other", i), cnt[C_OTHER], 32'd0);
         rd(A_STATUS, d);
         chk($sformatf("run%0d_status", i), d, 32'h2);
      end
      rd(A_STATUS, d);
      chk("status_done_cleared", d, 32'h0);

      // Multi-tile base stepping and restore.
      cfg(16, 1, 1, 3);
      wr(A_ABASE, 32'h100); wr(A_ASTR, 32'h40);
      wr(A_OBASE, 32'h200); wr(A_OSTR, 32'h10);
      wr(A_CTRL, 32'h1);
      observe();
      chk("tiles_entries", n_ent, 32'd3);
      chk("tile0_a", a_ent[0], 32'h100);
      chk("tile1_a", a_ent[1], 32'h140);
      chk("tile2_a", a_ent[2], 32'h180);
      chk("tile2_o", o_ent[2], 32'h220);
      chk("tiles_done_at", done_at, 32'd105);
      chk("idle_a_restored", a_base_addr, 32'h100);
      chk("idle_o_restored", o_base_addr, 32'h200);

      // Intranet mode: ROWS+COLS+1 cycles then FINISH.
      cfg(3, 5, 1, 1);
      wr(A_CTRL, 32'h2);
      observe();
      chk("intra_cycles",  cnt[C_INTRA], 32'd9);
      chk("intra_done_at", done_at,      32'd9);
      chk("intra_no_flow", cnt[C_FLOW],  32'd0);
      rd(A_STATUS, d);
      chk("intra_status", d, 32'h2);

      // Both starts together: OS wins.
      cfg(1, 1, 1, 1);
      wr(A_CTRL, 32'h3);
      observe();
      chk("both_flow",    cnt[C_FLOW],  32'd1);
      chk("both_intra",   cnt[C_INTRA], 32'd0);
      chk("both_done_at", done_at,      32'd20);
      rd(A_STATUS, d);

      // Abort beats start in IDLE.
      wr(A_CTRL, 32'h5);
      chk("abort_start_idle", 32'(busy_o), 32'd0);
      rd(A_STATUS, d);
      chk("abort_start_status", d, 32'h0);

      foreach (errs[i]) begin
         cfg(errs[i].rows, errs[i].cols, errs[i].k, 1);
         wr(A_CTRL, 32'h1);
         chk($sformatf("err%0d_busy", i), 32'(busy_o), 32'd0);
         rd(A_STATUS, d);
         chk($sformatf("err%0d_status", i), d, 32'h4);
         rd(A_STATUS, d);
         chk($sformatf("err%0d_status2", i), d, 32'h0);
      end

      // Abort in SKEW, with a ROWS write attempted mid-run.
      cfg(4, 4, 2, 1);
      wr(A_CTRL, 32'h1);
      @(negedge clk);
      wr(A_ROWS, 32'd9);
      chk("skew_reached", 32'(classify()), C_SKEW);
      cen = 1'b1; wen = 1'b1; addr = A_CTRL; wdata = 32'h4;
      #1;
      chk("abort_cycle_sa_reset", 32'(sa_reset), 32'd1);
      chk("abort_cycle_strobes", 32'({a_buf_on, w_buf_on, o_ag_o_on, op}), 32'd0);
      @(negedge clk);
      cen = 1'b0; wen = 1'b0; wdata = '0;
      chk("abort_idle", 32'(busy_o), 32'd0);
      chk("abort_idle_sa_reset", 32'(sa_reset), 32'd1);
      seen = 0;
      repeat (60) begin
         @(negedge clk);
         if (done_irq_o) seen++;
      end
      chk("abort_no_done", seen, 32'd0);
      rd(A_STATUS, d);
      chk("abort_status", d, 32'h0);
      rd(A_ROWS, d);
      chk("busy_write_ignored", d, 32'd4);

      // Asynchronous reset in STORE.
      cfg(2, 2, 1, 1);
      wr(A_ABASE, 32'h300);
      rd(A_ABASE, d);
      chk("pre_rst_rdata", d, 32'h300);
      wr(A_CTRL, 32'h1);
      got = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (o_ag_o_on) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("store_reached", 32'(got), 32'd1);
      #2 rst_ni = 1'b0;
      #1;
      chk("arst_busy",     32'(busy_o),   32'd0);
      chk("arst_sa_reset", 32'(sa_reset), 32'd1);
      chk("arst_strobes",  32'({a_buf_on, w_buf_on, o_ag_o_on, intranet_on, intra_sig_start, done_irq_o}), 32'd0);
      chk("arst_opcode",   32'(op),           32'd0);
      chk("arst_a_base",   a_base_addr,       32'd0);
      chk("arst_rows",     32'(a_num_rows),   32'd0);
      chk("arst_rdata",    rdata,             32'd0);
      @(negedge clk);
      rst_ni = 1'b1;
      seen = 0;
      repeat (30) begin
         @(negedge clk);
         if (done_irq_o) seen++;
      end
      chk("arst_no_done", seen, 32'd0);
      rd(A_STATUS, d);
      chk("arst_status", d, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
